// File: rtl/lsu_ecc_scrub_pkg.sv
// Shared types and constants for the DCCM single-bit-error scrub controller.
package lsu_ecc_scrub_pkg;

    // DC3 load/store packet: only the fields the scrubber looks at
    typedef struct packed {
        logic valid;
        logic load;
    } lsu_pkt_t;

    // Scrub write-back sequencing
    typedef enum logic [1:0] {
        SCRUB_IDLE  = 2'd0,
        SCRUB_WR_LO = 2'd1,
        SCRUB_WR_HI = 2'd2
    } scrub_state_t;

    // (39,32) Hamming check-bit masks over the 32 data bits; bit 6 is overall parity
    localparam logic [5:0][31:0] ECC_MASKS = {
        32'hFC000000,
        32'h03FFF800,
        32'h03FC07F0,
        32'hE3C3C78E,
        32'h9B33366D,
        32'h56AAAD5B
    };

endpackage

// File: rtl/lsu_ecc_scrub_ecc.sv
// SEC-DED check-bit generator for one 32-bit DCCM bank word.
module lsu_ecc_scrub_ecc
    import lsu_ecc_scrub_pkg::*;
(
    input  logic [31:0] din,
    output logic [6:0]  ecc_out
);

    logic [5:0] syn;

    // Hamming check bits, then overall parity across data and check bits
    always_comb begin
        syn = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            syn[i] = ^(din & ECC_MASKS[i]);
        end
        ecc_out = {(^din) ^ (^syn), syn};
    end

endmodule

// File: rtl/lsu_ecc_scrub.sv
// DCCM scrub controller: captures corrected load data after a single-bit ECC
// error and writes it back (with fresh ECC) to the failing bank(s).
module lsu_ecc_scrub
    import lsu_ecc_scrub_pkg::*;
#(
    parameter int DCCM_BITS       = 16,
    parameter int DCCM_DATA_WIDTH = 32,
    parameter int DCCM_ECC_WIDTH  = 7,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  lsu_pkt_t                   lsu_pkt_dc3,
    input  logic [DCCM_BITS-1:0]       lsu_addr_dc3,
    input  logic [DCCM_BITS-1:0]       end_addr_dc3,
    input  logic                       single_ecc_error_hi_dc3,
    input  logic                       single_ecc_error_lo_dc3,
    input  logic [DCCM_DATA_WIDTH-1:0] store_ecc_datafn_hi_dc3,
    input  logic [DCCM_DATA_WIDTH-1:0] store_ecc_datafn_lo_dc3,
    input  logic                       dec_tlu_core_ecc_disable,
    input  logic                       stbuf_wren,
    input  logic [DCCM_BITS-1:0]       stbuf_wraddr,
    input  logic                       scrub_gnt,
    input  logic                       ecc_count_clr,
    output logic                       scrub_req,
    output logic [DCCM_BITS-1:0]       scrub_wraddr,
    output logic [DCCM_DATA_WIDTH-1:0] scrub_wrdata,
    output logic [DCCM_ECC_WIDTH-1:0]  scrub_wrecc,
    output logic                       scrub_busy,
    output logic                       scrub_drop,
    output logic [CNT_WIDTH-1:0]       ecc_sec_count
);

    localparam logic [DCCM_BITS-1:0] WORD_MASK = {{(DCCM_BITS-2){1'b1}}, 2'b00};

    scrub_state_t               state, state_nxt;
    logic                       lo_pend, hi_pend;
    logic [DCCM_BITS-1:0]       lo_addr, hi_addr;
    logic [DCCM_DATA_WIDTH-1:0] lo_data, hi_data;
    logic                       cap, busy;
    logic                       lo_cancel, hi_cancel;
    logic                       lo_done, hi_done;
    logic [CNT_WIDTH:0]         cnt_sum;
    logic [CNT_WIDTH-1:0]       cnt_nxt;

    assign cap  = lsu_pkt_dc3.valid & lsu_pkt_dc3.load &
                  (single_ecc_error_hi_dc3 | single_ecc_error_lo_dc3) &
                  ~dec_tlu_core_ecc_disable;
    assign busy = (state != SCRUB_IDLE);

    // A store-buffer drain to a pending word supersedes the scrub of that word
    assign lo_cancel = lo_pend & stbuf_wren & ((stbuf_wraddr & WORD_MASK) == lo_addr);
    assign hi_cancel = hi_pend & stbuf_wren & ((stbuf_wraddr & WORD_MASK) == hi_addr);

    // Current half finishes on grant or on cancel; cancel suppresses the request
    assign lo_done   = (state == SCRUB_WR_LO) & (scrub_gnt | lo_cancel);
    assign hi_done   = (state == SCRUB_WR_HI) & (scrub_gnt | hi_cancel);
    assign scrub_req = ((state == SCRUB_WR_LO) & ~lo_cancel) |
                       ((state == SCRUB_WR_HI) & ~hi_cancel);

    assign scrub_busy   = busy;
    assign scrub_wraddr = (state == SCRUB_WR_HI) ? hi_addr : lo_addr;
    assign scrub_wrdata = (state == SCRUB_WR_HI) ? hi_data : lo_data;

    lsu_ecc_scrub_ecc u_ecc (
        .din     (scrub_wrdata),
        .ecc_out (scrub_wrecc)
    );

    // Next-state selection for the write-back sequence
    always_comb begin
        state_nxt = state;
        case (state)
            SCRUB_IDLE: begin
                if (cap) begin
                    state_nxt = single_ecc_error_lo_dc3 ? SCRUB_WR_LO : SCRUB_WR_HI;
                end
            end
            SCRUB_WR_LO: begin
                if (lo_done) begin
                    state_nxt = (hi_pend & ~hi_cancel) ? SCRUB_WR_HI : SCRUB_IDLE;
                end
            end
            SCRUB_WR_HI: begin
                if (hi_done) begin
                    state_nxt = SCRUB_IDLE;
                end
            end
            default: state_nxt = SCRUB_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= SCRUB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture of failing-bank addresses/data in IDLE; pend bits retire on grant or cancel
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lo_pend <= 1'b0;
            hi_pend <= 1'b0;
            lo_addr <= '0;
            hi_addr <= '0;
            lo_data <= '0;
            hi_data <= '0;
        end else if (!busy) begin
            if (cap) begin
                lo_pend <= single_ecc_error_lo_dc3;
                hi_pend <= single_ecc_error_hi_dc3;
                lo_addr <= lsu_addr_dc3 & WORD_MASK;
                hi_addr <= end_addr_dc3 & WORD_MASK;
                lo_data <= store_ecc_datafn_lo_dc3;
                hi_data <= store_ecc_datafn_hi_dc3;
            end
        end else begin
            if (lo_cancel | lo_done) begin
                lo_pend <= 1'b0;
            end
            if (hi_cancel | hi_done) begin
                hi_pend <= 1'b0;
            end
        end
    end

    // Sticky flag for SEC events lost because a scrub was already in progress
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            scrub_drop <= 1'b0;
        end else if (cap & busy) begin
            scrub_drop <= 1'b1;
        end
    end

    // Saturating add of 0..2 SEC events per qualified cycle
    always_comb begin
        cnt_sum = {1'b0, ecc_sec_count}
                + {{CNT_WIDTH{1'b0}}, single_ecc_error_lo_dc3}
                + {{CNT_WIDTH{1'b0}}, single_ecc_error_hi_dc3};
        cnt_nxt = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end

    // SEC event counter; clear takes priority over counting
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ecc_sec_count <= '0;
        end else if (ecc_count_clr) begin
            ecc_sec_count <= '0;
        end else if (cap) begin
            ecc_sec_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_lsu_ecc_scrub.sv
// Scoreboard bench for lsu_ecc_scrub: stimulus pushes expected write-backs,
// a negedge monitor pops and compares them and checks status outputs.
module tb_lsu_ecc_scrub;
    import lsu_ecc_scrub_pkg::*;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    lsu_pkt_t    pkt;
    logic [15:0] lsu_addr, end_addr, stbuf_wraddr;
    logic        se_hi, se_lo, ecc_dis, stbuf_wren, gnt, cnt_clr;
    logic [31:0] d_hi, d_lo;
    logic        scrub_req, scrub_busy, scrub_drop;
    logic [15:0] scrub_wraddr, ecc_sec_count;
    logic [31:0] scrub_wrdata;
    logic [6:0]  scrub_wrecc;

    lsu_ecc_scrub #(
        .DCCM_BITS       (16),
        .DCCM_DATA_WIDTH (32),
        .DCCM_ECC_WIDTH  (7),
        .CNT_WIDTH       (16)
    ) dut (
        .clk                      (clk),
        .rst_l                    (rst_l),
        .lsu_pkt_dc3              (pkt),
        .lsu_addr_dc3             (lsu_addr),
        .end_addr_dc3             (end_addr),
        .single_ecc_error_hi_dc3  (se_hi),
        .single_ecc_error_lo_dc3  (se_lo),
        .store_ecc_datafn_hi_dc3  (d_hi),
        .store_ecc_datafn_lo_dc3  (d_lo),
        .dec_tlu_core_ecc_disable (ecc_dis),
        .stbuf_wren               (stbuf_wren),
        .stbuf_wraddr             (stbuf_wraddr),
        .scrub_gnt                (gnt),
        .ecc_count_clr            (cnt_clr),
        .scrub_req                (scrub_req),
        .scrub_wraddr             (scrub_wraddr),
        .scrub_wrdata             (scrub_wrdata),
        .scrub_wrecc              (scrub_wrecc),
        .scrub_busy               (scrub_busy),
        .scrub_drop               (scrub_drop),
        .ecc_sec_count            (ecc_sec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit v, ld, lo, hi, dis, sw, g, clr;
        logic [15:0] a, ea, sa;
        logic [31:0] dlo, dhi;
    } stim_t;

    wr_t         exp_q[$];
    wr_t         pend_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned m_cnt = 0;
    bit          m_drop = 0;
    bit          cur_busy = 0, cur_req = 0, cur_drop = 0;
    int unsigned cur_cnt = 0;
    bit          started = 0, in_reset = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference ECC: build the 38-position Hamming codeword explicitly
    function automatic logic [6:0] ref_ecc(input logic [31:0] d);
        logic [38:1] cw;
        logic [6:0]  e;
        int          di;
        cw = '0;
        e  = '0;
        di = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[di];
                di++;
            end
        end
        for (int k = 0; k < 6; k++)
            for (int p = 1; p <= 38; p++)
                if (((p >> k) & 1) == 1) e[k] = e[k] ^ cw[p];
        e[6] = (^d) ^ (^e[5:0]);
        return e;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s.v = 0; s.ld = 0; s.lo = 0; s.hi = 0; s.dis = 0; s.sw = 0; s.g = 0; s.clr = 0;
        s.a = '0; s.ea = '0; s.sa = '0; s.dlo = '0; s.dhi = '0;
        return s;
    endfunction

    function automatic stim_t cap_stim(input logic [15:0] a, input logic [15:0] ea,
                                       input bit lo, input bit hi,
                                       input logic [31:0] dlo, input logic [31:0] dhi);
        stim_t s;
        s = idle_stim();
        s.v = 1; s.ld = 1; s.lo = lo; s.hi = hi;
        s.a = a; s.ea = ea; s.dlo = dlo; s.dhi = dhi;
        return s;
    endfunction

    // One cycle: drive inputs, record what is visible this cycle, advance the model
    task automatic step(input stim_t s);
        bit cap, head_hit;
        pkt.valid    = s.v;
        pkt.load     = s.ld;
        se_lo        = s.lo;
        se_hi        = s.hi;
        ecc_dis      = s.dis;
        lsu_addr     = s.a;
        end_addr     = s.ea;
        d_lo         = s.dlo;
        d_hi         = s.dhi;
        stbuf_wren   = s.sw;
        stbuf_wraddr = s.sa;
        gnt          = s.g;
        cnt_clr      = s.clr;

        cur_busy = (pend_q.size() != 0);
        cur_cnt  = m_cnt;
        cur_drop = m_drop;
        head_hit = cur_busy && s.sw && (pend_q[0].addr[15:2] == s.sa[15:2]);
        cur_req  = cur_busy && !head_hit;

        cap = s.v && s.ld && (s.lo || s.hi) && !s.dis;
        if (s.clr) m_cnt = 0;
        else if (cap) begin
            m_cnt = m_cnt + s.lo + s.hi;
            if (m_cnt > 32'hFFFF) m_cnt = 32'hFFFF;
        end
        if (cap && cur_busy) m_drop = 1;
        if (cap && !cur_busy) begin
            wr_t w;
            if (s.lo) begin
                w.addr = {s.a[15:2], 2'b00}; w.data = s.dlo;
                pend_q.push_back(w); exp_q.push_back(w);
            end
            if (s.hi) begin
                w.addr = {s.ea[15:2], 2'b00}; w.data = s.dhi;
                pend_q.push_back(w); exp_q.push_back(w);
            end
        end
        if (cur_busy) begin
            if (s.sw) begin
                for (int i = int'(pend_q.size()) - 1; i >= 0; i--)
                    if (pend_q[i].addr[15:2] == s.sa[15:2]) pend_q.delete(i);
                for (int i = int'(exp_q.size()) - 1; i >= 0; i--)
                    if (exp_q[i].addr[15:2] == s.sa[15:2]) exp_q.delete(i);
            end else if (s.g) begin
                void'(pend_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: status outputs every cycle, write-backs against the scoreboard
    always @(negedge clk) begin
        if (started && !in_reset && rst_l) begin
            assert (!(gnt && stbuf_wren)) else begin
                errors++;
                $display("FAIL gnt_with_stbuf actual=1 required=0 at %0t", $time);
            end
            chk("busy", scrub_busy, cur_busy);
            chk("req", scrub_req, cur_req);
            chk("count", ecc_sec_count, cur_cnt);
            chk("drop", scrub_drop, cur_drop);
            if (scrub_req && gnt) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h required=none at %0t", scrub_wraddr, $time);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("wraddr", scrub_wraddr, w.addr);
                    chk("wrdata", scrub_wrdata, w.data);
                    chk("wrecc", scrub_wrecc, ref_ecc(w.data));
                end
            end
        end
    end

    initial begin
        stim_t s;
        pkt = '0; lsu_addr = '0; end_addr = '0; stbuf_wraddr = '0;
        se_hi = 0; se_lo = 0; ecc_dis = 0; stbuf_wren = 0; gnt = 0; cnt_clr = 0;
        d_hi = '0; d_lo = '0;

        // Reset values
        #1;
        chk("rst_req", scrub_req, 0);
        chk("rst_busy", scrub_busy, 0);
        chk("rst_drop", scrub_drop, 0);
        chk("rst_count", ecc_sec_count, 0);
        chk("rst_wraddr", scrub_wraddr, 0);
        chk("rst_wrdata", scrub_wrdata, 0);
        #20;
        rst_l = 1;
        @(posedge clk);
        #1;
        started = 1;

        // Lo-only SEC, grant held high: single write in the cycle after capture
        s = cap_stim(16'h0100, 16'h0103, 1, 0, 32'hDEADBEEF, 32'h0);
        s.g = 1;
        step(s);
        s = idle_stim(); s.g = 1;
        step(s);
        step(s);

        // Dual-bank SEC, grant delayed three cycles
        step(cap_stim(16'h0106, 16'h0109, 1, 1, 32'hA5A5_1234, 32'h5A5A_8765));
        for (int i = 0; i < 3; i++) step(idle_stim());
        s = idle_stim(); s.g = 1;
        step(s);
        step(s);
        step(idle_stim());

        // Store-buffer hazard cancels the pending lo write
        step(cap_stim(16'h0200, 16'h0203, 1, 0, 32'hCAFEF00D, 32'h0));
        s = idle_stim(); s.sw = 1; s.sa = 16'h0202;
        step(s);
        step(idle_stim());
        step(idle_stim());

        // Second SEC while busy: dropped, still counted, first data kept
        step(cap_stim(16'h0300, 16'h0303, 1, 0, 32'h1111_1111, 32'h0));
        step(cap_stim(16'h0400, 16'h0403, 1, 0, 32'h2222_2222, 32'h0));
        s = idle_stim(); s.g = 1;
        step(s);
        step(idle_stim());

        // Disabled ECC and store packets are ignored
        s = cap_stim(16'h0500, 16'h0503, 1, 0, 32'h3333_3333, 32'h0);
        s.dis = 1;
        step(s);
        s = cap_stim(16'h0506, 16'h0509, 1, 1, 32'h4444_4444, 32'h5555_5555);
        s.ld = 0;
        step(s);
        step(idle_stim());

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            int unsigned sz;
            s = idle_stim();
            s.v   = ($urandom_range(0, 9) != 0);
            s.ld  = ($urandom_range(0, 4) != 0);
            s.dis = ($urandom_range(0, 9) == 0);
            sz    = (1 << $urandom_range(0, 2));
            s.a   = 16'($urandom);
            s.ea  = s.a + 16'(sz - 1);
            if ($urandom_range(0, 3) == 0) begin
                s.lo = 1'($urandom_range(0, 1));
                s.hi = (s.a[15:2] != s.ea[15:2]) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            s.dlo = $urandom;
            s.dhi = $urandom;
            s.sw  = ($urandom_range(0, 4) == 0);
            if (s.sw && pend_q.size() != 0 && $urandom_range(0, 1) == 1)
                s.sa = {pend_q[$urandom_range(0, pend_q.size() - 1)].addr[15:2], 2'($urandom)};
            else
                s.sa = 16'($urandom);
            s.g   = !s.sw && ($urandom_range(0, 1) == 1);
            s.clr = ($urandom_range(0, 199) == 0);
            step(s);
        end

        // Drain, bounded
        for (int i = 0; i < 8 && pend_q.size() != 0; i++) begin
            s = idle_stim(); s.g = 1;
            step(s);
        end
        step(idle_stim());
        chk("drain_empty", exp_q.size(), 0);

        // Saturation: clear, then enough dual-bank events to pass all-ones
        s = idle_stim(); s.clr = 1;
        step(s);
        for (int i = 0; i < 32769; i++)
            step(cap_stim(16'h0106, 16'h0109, 1, 1, 32'h600D_0001, 32'h600D_0002));
        step(idle_stim());
        chk("saturated", ecc_sec_count, 16'hFFFF);
        for (int i = 0; i < 8 && pend_q.size() != 0; i++) begin
            s = idle_stim(); s.g = 1;
            step(s);
        end
        step(idle_stim());

        // Reset asserted while in WR_HI
        step(cap_stim(16'h0706, 16'h0709, 1, 1, 32'h7777_0000, 32'h8888_0000));
        s = idle_stim(); s.g = 1;
        step(s);
        chk("in_wr_hi_req", scrub_req, 1);
        chk("in_wr_hi_addr", scrub_wraddr, 16'h0708);
        in_reset = 1;
        rst_l = 0;
        #1;
        chk("async_req", scrub_req, 0);
        chk("async_busy", scrub_busy, 0);
        chk("async_count", ecc_sec_count, 0);
        pend_q.delete();
        exp_q.delete();
        m_cnt  = 0;
        m_drop = 0;
        @(posedge clk);
        #2;
        rst_l = 1;
        @(posedge clk);
        #1;
        in_reset = 0;
        step(idle_stim());
        step(idle_stim());
        chk("post_rst_busy", scrub_busy, 0);
        chk("post_rst_drop", scrub_drop, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_ecc_scrub.md
# lsu_ecc_scrub

DCCM single-bit-error write-back (scrub) controller, directly downstream of the LSU ECC decode stage. It captures the corrected DCCM word(s) for a load that reported a single ECC error in DC3. It then requests the DCCM write port and writes the corrected data with freshly encoded ECC back to the failing bank(s), so the error does not accumulate into an uncorrectable one. It also keeps a saturating SEC event counter for the TLU.

## Interface
Parameters:
- DCCM_BITS, 16, DCCM byte-address width
- DCCM_DATA_WIDTH, 32, bank data width
- DCCM_ECC_WIDTH, 7, bank ECC width
- CNT_WIDTH, 16, SEC counter width

Ports:
- clk  in  1  core clock; the single clock
- rst_l  in  1  reset; asynchronous, active-low
- lsu_pkt_dc3  in  lsu_pkt_t  DC3 packet (uses valid, load)
- lsu_addr_dc3, end_addr_dc3  in  DCCM_BITS  start/end byte address
- single_ecc_error_hi_dc3, single_ecc_error_lo_dc3  in  1  per-bank SEC flags
- store_ecc_datafn_hi_dc3, store_ecc_datafn_lo_dc3  in  DCCM_DATA_WIDTH  corrected/merged bank data
- dec_tlu_core_ecc_disable  in  1  suppresses capture and counting
- stbuf_wren  in  1  store-buffer drain write this cycle
- stbuf_wraddr  in  DCCM_BITS  store-buffer drain address
- scrub_gnt  in  1  DCCM write-port grant from the DCCM controller
- ecc_count_clr  in  1  synchronous counter clear
- scrub_req  out  1  DCCM write request
- scrub_wraddr  out  DCCM_BITS  word-aligned write address ([1:0]=0)
- scrub_wrdata  out  DCCM_DATA_WIDTH  write data
- scrub_wrecc  out  DCCM_ECC_WIDTH  ECC of scrub_wrdata
- scrub_busy  out  1  state != IDLE
- scrub_drop  out  1  sticky: an SEC event arrived while busy
- ecc_sec_count  out  CNT_WIDTH  saturating SEC event count

## Operation
- Capture condition (DC3): cap = lsu_pkt_dc3.valid & lsu_pkt_dc3.load & (single_ecc_error_hi_dc3 | single_ecc_error_lo_dc3) & ~dec_tlu_core_ecc_disable. Stores are never scrubbed; their merged word reaches DCCM through the store buffer.
- On cap in IDLE, register the following:
  - lo_pend = single_ecc_error_lo_dc3, lo_addr = {lsu_addr_dc3[DCCM_BITS-1:2],2'b00}, lo_data = store_ecc_datafn_lo_dc3.
  - hi_pend = single_ecc_error_hi_dc3, hi_addr = {end_addr_dc3[DCCM_BITS-1:2],2'b00}, hi_data = store_ecc_datafn_hi_dc3.
- FSM states are IDLE, WR_LO and WR_HI.
  - IDLE: on cap, go to WR_LO if lo SEC, else WR_HI.
  - WR_LO: scrub_req=1. On scrub_gnt, go to WR_HI if hi_pend, else IDLE.
  - WR_HI: scrub_req=1. On scrub_gnt, go to IDLE.
- Outputs: scrub_wraddr/scrub_wrdata select the lo or hi registers by state. scrub_wrecc is computed combinationally from scrub_wrdata.
- Store-buffer hazard: when stbuf_wren and stbuf_wraddr[DCCM_BITS-1:2] matches the address of a pending half, clear that half's pend. This prevents overwriting newer store data.
  - A cancelled current half advances the FSM as if granted.
  - If stbuf_wren and scrub_gnt hit the same half in the same cycle, the cancel wins and no write occurs. The DCCM controller never grants both in one cycle; the bench asserts this.
- cap while busy: nothing is captured, scrub_drop sets (cleared only by reset), and the counter still counts.
- Counter: adds single_ecc_error_lo_dc3 + single_ecc_error_hi_dc3 (0..2) on every cap-qualified cycle, busy or not. It saturates at all-ones. ecc_count_clr has priority over increment.
- Reset: all outputs and state are 0/IDLE. Assertion mid-operation abandons any pending write; scrub_req drops asynchronously.

## Timing
- Capture is at the clock edge ending DC3. scrub_req rises in the next cycle (DC4).
- The write occurs in the cycle where scrub_req & scrub_gnt. The FSM advances at the end of that cycle.
- Minimum occupancy: one cycle per bank, two cycles for a dual-bank error.
- scrub_busy equals the registered state; there is no combinational path from cap to scrub_busy.
- ecc_sec_count updates one cycle after the DC3 event.

## Structure
- Add the FSM state enum (scrub_state_t) to swerv_types; widths come from the existing RV_DCCM_* defines.
- Reuse a single rvecc_encode instance on the muxed scrub_wrdata. No new sub-module is needed.

## Test plan
- Lo-only SEC: load at 0x0100, lo error, data 0xDEADBEEF, scrub_gnt held high → one write: addr 0x0100, data 0xDEADBEEF, correct ECC, in the cycle after capture; then IDLE.
- Dual-bank SEC: load at 0x0106 (end 0x0109), both flags set, grant delayed 3 cycles → lo write to 0x0104, then hi write to 0x0108; counter +2.
- Hazard: lo pending at 0x0200, stbuf_wren to 0x0202 before grant → no write; FSM returns to IDLE.
- Busy drop: second SEC arrives while in WR_LO with no grant → scrub_drop=1, counter increments, captured data unchanged.
- Disable/store: SEC flags set with dec_tlu_core_ecc_disable=1, or with a store packet → no scrub_req, counter unchanged.
- Saturation/reset: counter preset to 0xFFFF, plus another SEC → stays 0xFFFF. rst_l low during WR_HI → scrub_req=0 immediately and state is IDLE after release.
